rvtu_div_arb_n: RTL
===================

// Module: rvtu_div_arb_n
// PURPOSE
//  N-channel shared iterative divider for RVTU clusters; successor of the 2-port div arbiter.
//  Round-robin arbitrates NUM_CH core div ports onto one radix-2 restoring divider.
//  Computes RV32M DIV/DIVU/REM/REMU, with a 1-cycle fast path for special cases.
//  Optional DIV/REM operand reuse returns the paired result without re-iteration.
// PARAMETERS
//  NUM_CH    2   number of requesting channels, >=1
//  WIDTH     32  operand/result width, >=2
//  REUSE_EN  1   1: enable last-operand result reuse; 0: every op iterates or takes the special path
// PORTS
//  clk    in   1               clock
//  rst_n  in   1               async active-low reset
//  req    in   NUM_CH          per-channel request, level, held until resp
//  src1   in   NUM_CH x WIDTH  dividend, stable while req high
//  src2   in   NUM_CH x WIDTH  divisor, stable while req high
//  fsel   in   NUM_CH x 2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//  resp   out  NUM_CH          1-cycle completion pulse, onehot0
//  out    out  NUM_CH x WIDTH  result, valid only when resp[ch]=1, else 0
//  busy   out  1               state != IDLE
// BEHAVIOUR
//  Reset (rst_n low, async, any state):
//   - State -> IDLE; resp=0; out=0; busy=0.
//   - rr_ptr=0; reuse_vld=0; any in-flight op is discarded (no resp).
//  FSM IDLE -> {CALC | DONE} -> DONE -> IDLE.
//  IDLE:
//   - Grant the first req[] high scanning from rr_ptr upward, with wrap.
//   - Latch grant index, |src1|, |src2|, fsel, and result sign flags.
//   - Special case or reuse hit -> DONE; else -> CALC with cnt=WIDTH-1. No req -> stay IDLE.
//  CALC:
//   - One restoring-division step per cycle on unsigned magnitudes.
//   - cnt==0 -> DONE. Total WIDTH cycles.
//  DONE:
//   - resp[g]=1 and out[g]=result for exactly one cycle, then IDLE; rr_ptr=(g+1) mod NUM_CH.
//  Latency, req first high at edge t while IDLE:
//   - normal: resp high in cycle t+WIDTH+1
//   - special/reuse: resp high in cycle t+1
//   - A waiting channel is granted in the IDLE cycle after the current DONE.
//  Handshake:
//   - Requester clears req at the edge where it samples resp=1; req is low in the following IDLE cycle.
//   - Operand/fsel changes while req high are illegal; latched values govern the op.
//   - req of non-granted channels is ignored until IDLE.
//  Signed ops (fsel[0]=0):
//   - Operate on magnitudes.
//   - Quotient negated iff src1 and src2 signs differ; remainder takes the sign of src1.
//  Special cases, highest priority first:
//   - src2==0: quotient all-ones, remainder = src1 (signed and unsigned).
//   - signed src1==MIN(1<<(WIDTH-1)), src2==all-ones: quotient = MIN, remainder 0.
//  Reuse (REUSE_EN=1):
//   - Every completion stores src1, src2, fsel[0], quotient, remainder; reuse_vld=1.
//   - Hit = reuse_vld & src1,src2,fsel[0] equal to stored; return stored quotient or remainder per fsel[1].
//   - Special cases take the special path, not reuse.
//  NUM_CH=1: rr_ptr held at 0; behaviour otherwise identical.
// TESTING
//  - NUM_CH=2, WIDTH=32, ch0 DIV 100/-7 -> resp[0] 33 cycles after req, out=-14 (0xFFFFFFF2); REM same -> 2 via reuse, latency 1.
//  - ch0,ch1 req same cycle from reset -> ch0 served first, then ch1; ch0 reissue during ch1 op -> ch0 after ch1 (rr order 0,1,0).
//  - DIVU 5/0 -> out=0xFFFFFFFF at t+1; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same -> 0.
//  - NUM_CH=4, all four req continuously re-armed -> grants 0,1,2,3,0; no channel waits >3 ops; resp onehot0 always.
//  - rst_n low mid-CALC, cnt=10 -> immediate resp=0, busy=0; after release, same op re-run by ch0 -> correct result, no stale reuse hit.
//  - REUSE_EN=0, DIV then REM 7/2 -> both take WIDTH+1 latency; outputs 3 then 1. Also DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/rvtu_div_arb_n_if.sv
// Request/response bundle between NUM_CH requesting cores and the shared divider.
// The master side drives requests and operands; the slave side returns results.
interface rvtu_div_arb_n_if #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 32
);
  logic [NUM_CH-1:0]            req;
  logic [NUM_CH-1:0][WIDTH-1:0] src1;
  logic [NUM_CH-1:0][WIDTH-1:0] src2;
  logic [NUM_CH-1:0][1:0]       fsel;
  logic [NUM_CH-1:0]            resp;
  logic [NUM_CH-1:0][WIDTH-1:0] out;
  logic                         busy;

  modport master (output req, src1, src2, fsel, input resp, out, busy);
  modport slave  (input req, src1, src2, fsel, output resp, out, busy);
endinterface

// File: rtl/rvtu_div_arb_n.sv
// N-channel round-robin arbiter in front of one radix-2 restoring divider
// (RV32M DIV/DIVU/REM/REMU) with a single-cycle special/reuse path.
module rvtu_div_arb_n #(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 32,
  parameter int REUSE_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  rvtu_div_arb_n_if.slave bus
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    LAST_CH = IW'(NUM_CH - 1);
  localparam logic             REUSE_ON = (REUSE_EN != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_n;
  logic [IW-1:0]                r_gnt;
  logic [IW-1:0]                r_rr_ptr;
  logic [CW-1:0]                r_cnt;
  logic [1:0]                   r_fsel;
  logic                         r_neg_q;
  logic                         r_neg_r;
  logic [WIDTH-1:0]             r_quo;
  logic [WIDTH-1:0]             r_rem;
  logic [WIDTH-1:0]             r_dvs;
  logic [WIDTH-1:0]             r_s1;
  logic [WIDTH-1:0]             r_s2;
  logic                         r_rv_vld;
  logic [WIDTH-1:0]             r_rv_s1;
  logic [WIDTH-1:0]             r_rv_s2;
  logic                         r_rv_uns;
  logic [WIDTH-1:0]             r_rv_q;
  logic [WIDTH-1:0]             r_rv_r;
  logic [NUM_CH-1:0]            r_resp;
  logic [NUM_CH-1:0][WIDTH-1:0] r_out;
  logic                         r_busy;

  logic                         w_found;
  logic [IW-1:0]                w_gnt;
  logic [IW:0]                  w_sum;
  logic [WIDTH-1:0]             w_s1;
  logic [WIDTH-1:0]             w_s2;
  logic [1:0]                   w_fs;
  logic                         w_sgn;
  logic                         w_div0;
  logic                         w_ovf;
  logic                         w_hit;
  logic                         w_fast;
  logic [WIDTH:0]               w_shift;
  logic [WIDTH:0]               w_diff;
  logic [WIDTH-1:0]             w_quo_n;
  logic [WIDTH-1:0]             w_rem_n;
  logic [WIDTH-1:0]             w_cq;
  logic [WIDTH-1:0]             w_cr;
  logic [WIDTH-1:0]             w_c_s1;
  logic [WIDTH-1:0]             w_c_s2;
  logic                         w_c_uns;
  logic                         w_c_rsel;
  logic [IW-1:0]                w_c_gnt;
  logic                         w_done_entry;

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic sgn);
    f_abs = (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic neg);
    f_cneg = neg ? (~v + ONE_W) : v;
  endfunction

  // Round-robin pick: first requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum   = {1'b0, r_rr_ptr} + (IW+1)'(i);
      w_sum   = (w_sum >= (IW+1)'(NUM_CH)) ? (w_sum - (IW+1)'(NUM_CH)) : w_sum;
      w_gnt   = (!w_found && bus.req[w_sum[IW-1:0]]) ? w_sum[IW-1:0] : w_gnt;
      w_found = w_found | bus.req[w_sum[IW-1:0]];
    end
  end

  assign w_s1   = bus.src1[w_gnt];
  assign w_s2   = bus.src2[w_gnt];
  assign w_fs   = bus.fsel[w_gnt];
  assign w_sgn  = ~w_fs[0];
  assign w_div0 = (w_s2 == ZERO_W);
  assign w_ovf  = w_sgn & (w_s1 == MIN_W) & (w_s2 == ONES_W);
  assign w_hit  = REUSE_ON & r_rv_vld & (w_s1 == r_rv_s1) & (w_s2 == r_rv_s2) & (w_fs[0] == r_rv_uns);
  assign w_fast = w_div0 | w_ovf | w_hit;

  // Restoring step: a borrow out of the trial subtraction keeps the shifted remainder.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_quo_n = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_rem_n = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

  // Result and reuse-record values for the cycle that enters DONE.
  always_comb begin
    w_cq     = f_cneg(w_quo_n, r_neg_q);
    w_cr     = f_cneg(w_rem_n, r_neg_r);
    w_c_s1   = r_s1;
    w_c_s2   = r_s2;
    w_c_uns  = r_fsel[0];
    w_c_rsel = r_fsel[1];
    w_c_gnt  = r_gnt;
    if (r_state == ST_IDLE) begin
      w_c_s1   = w_s1;
      w_c_s2   = w_s2;
      w_c_uns  = w_fs[0];
      w_c_rsel = w_fs[1];
      w_c_gnt  = w_gnt;
      if (w_div0) begin
        w_cq = ONES_W;
        w_cr = w_s1;
      end else if (w_ovf) begin
        w_cq = MIN_W;
        w_cr = ZERO_W;
      end else begin
        w_cq = r_rv_q;
        w_cr = r_rv_r;
      end
    end else begin
      w_c_gnt = r_gnt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_n = w_fast ? ST_DONE : ST_CALC;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_cnt == CW'(0)) begin
          w_state_n = ST_DONE;
        end else begin
          w_state_n = ST_CALC;
        end
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign w_done_entry = (w_state_n == ST_DONE) && (r_state != ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Operand latch, iteration datapath and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_fsel   <= 2'b00;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_quo    <= ZERO_W;
      r_rem    <= ZERO_W;
      r_dvs    <= ZERO_W;
      r_s1     <= ZERO_W;
      r_s2     <= ZERO_W;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_gnt;
            r_fsel  <= w_fs;
            r_s1    <= w_s1;
            r_s2    <= w_s2;
            r_neg_q <= w_sgn & (w_s1[WIDTH-1] ^ w_s2[WIDTH-1]);
            r_neg_r <= w_sgn & w_s1[WIDTH-1];
            r_quo   <= f_abs(w_s1, w_sgn);
            r_dvs   <= f_abs(w_s2, w_sgn);
            r_rem   <= ZERO_W;
            r_cnt   <= CW'(WIDTH - 1);
          end
        end
        ST_CALC: begin
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          r_cnt <= r_cnt - CW'(1);
        end
        ST_DONE: begin
          r_rr_ptr <= (r_gnt == LAST_CH) ? '0 : (r_gnt + IW'(1));
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Last-completion record used for DIV/REM pairing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rv_vld <= 1'b0;
      r_rv_s1  <= ZERO_W;
      r_rv_s2  <= ZERO_W;
      r_rv_uns <= 1'b0;
      r_rv_q   <= ZERO_W;
      r_rv_r   <= ZERO_W;
    end else if (w_done_entry) begin
      r_rv_vld <= REUSE_ON;
      r_rv_s1  <= w_c_s1;
      r_rv_s2  <= w_c_s2;
      r_rv_uns <= w_c_uns;
      r_rv_q   <= w_cq;
      r_rv_r   <= w_cr;
    end
  end

  // Registered outputs: resp/out are asserted exactly for the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp <= '0;
      r_out  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_resp <= '0;
      r_out  <= '0;
      r_busy <= (w_state_n != ST_IDLE);
      if (w_done_entry) begin
        r_resp[w_c_gnt] <= 1'b1;
        r_out[w_c_gnt]  <= w_c_rsel ? w_cr : w_cq;
      end
    end
  end

  assign bus.resp = r_resp;
  assign bus.out  = r_out;
  assign bus.busy = r_busy;
endmodule
